// File: rtl/tl_ul_a_arbiter.sv
// tl_ul_a_arbiter
// Two-requester TileLink-UL arbiter that shares one downstream A/D port.
//   A channel : round-robin grant. Multi-beat Put messages keep the grant until
//               their last beat. The grant index is prepended as the MSB of
//               out_a_source.
//   D channel : zero-latency routing back to the requester named by
//               out_d_source[SRC_W]. The D fields go to both requesters, and
//               only the selected requester sees valid.
// Ports:
//   clock, reset_n (async, active-low)
//   a0_*/a1_*      upstream A requests          out_a_*  downstream A
//   out_d_*        downstream D responses       d0_*/d1_* upstream D
//   err_size       sticky: an A first beat had size > MAX_SIZE
//   dbg_state      FSM state (0 = IDLE, 1 = BURST)
// Handshake: every channel uses valid/ready. A beat transfers on a rising
//   clock edge where valid & ready are both high. Valid never depends on ready.
//   Once valid is raised it is held with stable fields until the transfer.
// Optional build macro: TL_ARB_INFLIGHT_LIMIT_EN. It adds per-requester
//   outstanding-message counters. A requester with MAX_INFLIGHT open messages
//   is left out of new arbitration.
module tl_ul_a_arbiter #(
    parameter int SRC_W        = 3,
    parameter int MAX_SIZE     = 6,
    parameter int MAX_INFLIGHT = 4
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               a0_valid,
    output logic               a0_ready,
    input  logic [2:0]         a0_opcode,
    input  logic [2:0]         a0_param,
    input  logic [3:0]         a0_size,
    input  logic [SRC_W-1:0]   a0_source,
    input  logic [31:0]        a0_address,
    input  logic [3:0]         a0_mask,
    input  logic [31:0]        a0_data,
    input  logic               a1_valid,
    output logic               a1_ready,
    input  logic [2:0]         a1_opcode,
    input  logic [2:0]         a1_param,
    input  logic [3:0]         a1_size,
    input  logic [SRC_W-1:0]   a1_source,
    input  logic [31:0]        a1_address,
    input  logic [3:0]         a1_mask,
    input  logic [31:0]        a1_data,
    output logic               out_a_valid,
    input  logic               out_a_ready,
    output logic [2:0]         out_a_opcode,
    output logic [2:0]         out_a_param,
    output logic [3:0]         out_a_size,
    output logic [SRC_W:0]     out_a_source,
    output logic [31:0]        out_a_address,
    output logic [3:0]         out_a_mask,
    output logic [31:0]        out_a_data,
    input  logic               out_d_valid,
    output logic               out_d_ready,
    input  logic [2:0]         out_d_opcode,
    input  logic [1:0]         out_d_param,
    input  logic [3:0]         out_d_size,
    input  logic [SRC_W:0]     out_d_source,
    input  logic               out_d_denied,
    input  logic [31:0]        out_d_data,
    input  logic               out_d_corrupt,
    output logic               d0_valid,
    input  logic               d0_ready,
    output logic [2:0]         d0_opcode,
    output logic [1:0]         d0_param,
    output logic [3:0]         d0_size,
    output logic [SRC_W-1:0]   d0_source,
    output logic               d0_denied,
    output logic [31:0]        d0_data,
    output logic               d0_corrupt,
    output logic               d1_valid,
    input  logic               d1_ready,
    output logic [2:0]         d1_opcode,
    output logic [1:0]         d1_param,
    output logic [3:0]         d1_size,
    output logic [SRC_W-1:0]   d1_source,
    output logic               d1_denied,
    output logic [31:0]        d1_data,
    output logic               d1_corrupt,
    output logic               err_size,
    output logic               dbg_state
);
    // The counter width fits the largest message: 1 << (MAX_SIZE-2) beats.
    localparam int BEAT_W = MAX_SIZE - 1;

    typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

    state_t            state;
    logic              prio, hold, hold_idx, burst_idx;
    logic [BEAT_W-1:0] beat_cnt;
    logic              grant, gnt_valid, req0, req1, blk0, blk1, ready_ok, fire;
    logic [3:0]        g_size;
    logic [2:0]        g_opcode;
    logic [BEAT_W-1:0] g_beats;
    logic              sel;

    // A multi-beat message carries data beats. The size is clamped, so an
    // oversized message still has a bounded length.
    function automatic logic [BEAT_W-1:0] beats_of(input logic multi, input logic [3:0] size);
        logic [3:0] s;
        s = (size > 4'(MAX_SIZE)) ? 4'(MAX_SIZE) : size;
        if (multi && s > 4'd2) return BEAT_W'(1) << (s - 4'd2);
        else                   return BEAT_W'(1);
    endfunction

    always_comb begin
        req0 = a0_valid & ~blk0;
        req1 = a1_valid & ~blk1;
        if (state == BURST)   grant = burst_idx;
        else if (hold)        grant = hold_idx;
        else if (req0 & req1) grant = prio;
        else                  grant = req1;
        // A grant that is locked (burst or hold) ignores the inflight mask.
        // Only a fresh IDLE choice is filtered by it.
        if (state == IDLE && !hold) begin
            gnt_valid = req0 | req1;
            ready_ok  = ~(grant ? blk1 : blk0);
        end else begin
            gnt_valid = grant ? a1_valid : a0_valid;
            ready_ok  = 1'b1;
        end
    end

    assign out_a_valid   = reset_n & gnt_valid;
    assign a0_ready      = reset_n & out_a_ready & ~grant & ready_ok;
    assign a1_ready      = reset_n & out_a_ready &  grant & ready_ok;
    assign fire          = out_a_valid & out_a_ready;

    assign g_opcode      = grant ? a1_opcode : a0_opcode;
    assign g_size        = grant ? a1_size   : a0_size;
    assign g_beats       = beats_of(g_opcode == 3'd0 || g_opcode == 3'd1, g_size);
    assign out_a_opcode  = g_opcode;
    assign out_a_size    = g_size;
    assign out_a_param   = grant ? a1_param   : a0_param;
    assign out_a_address = grant ? a1_address : a0_address;
    assign out_a_mask    = grant ? a1_mask    : a0_mask;
    assign out_a_data    = grant ? a1_data    : a0_data;
    assign out_a_source  = {grant, grant ? a1_source : a0_source};
    assign dbg_state     = (state == BURST);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            prio      <= 1'b0;
            hold      <= 1'b0;
            hold_idx  <= 1'b0;
            burst_idx <= 1'b0;
            beat_cnt  <= '0;
            err_size  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (fire) begin
                        hold <= 1'b0;
                        if (g_size > 4'(MAX_SIZE)) err_size <= 1'b1;
                        if (g_beats != BEAT_W'(1)) begin
                            beat_cnt  <= g_beats - 1'b1;
                            burst_idx <= grant;
                            state     <= BURST;
                        end else begin
                            prio <= ~grant;
                        end
                    end else if (out_a_valid && !hold) begin
                        // The offered beat stalled. Freeze the choice so the
                        // A fields stay stable until it transfers.
                        hold     <= 1'b1;
                        hold_idx <= grant;
                    end
                end
                BURST: begin
                    if (fire) begin
                        beat_cnt <= beat_cnt - 1'b1;
                        if (beat_cnt == BEAT_W'(1)) begin
                            state <= IDLE;
                            prio  <= ~burst_idx;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // D channel: route by the source MSB that the A side prepended.
    assign sel         = out_d_source[SRC_W];
    assign d0_valid    = reset_n & out_d_valid & ~sel;
    assign d1_valid    = reset_n & out_d_valid &  sel;
    assign out_d_ready = reset_n & (sel ? d1_ready : d0_ready);
    assign d0_opcode   = out_d_opcode;
    assign d1_opcode   = out_d_opcode;
    assign d0_param    = out_d_param;
    assign d1_param    = out_d_param;
    assign d0_size     = out_d_size;
    assign d1_size     = out_d_size;
    assign d0_source   = out_d_source[SRC_W-1:0];
    assign d1_source   = out_d_source[SRC_W-1:0];
    assign d0_denied   = out_d_denied;
    assign d1_denied   = out_d_denied;
    assign d0_data     = out_d_data;
    assign d1_data     = out_d_data;
    assign d0_corrupt  = out_d_corrupt;
    assign d1_corrupt  = out_d_corrupt;

`ifdef TL_ARB_INFLIGHT_LIMIT_EN
    localparam int CNT_W = $clog2(MAX_INFLIGHT + 1);
    logic [CNT_W-1:0]  cnt0, cnt1;
    logic [BEAT_W-1:0] d_cnt, d_beats;
    logic              d_fire, d_last, inc0, inc1, dec0, dec1;

    assign blk0    = (cnt0 == CNT_W'(MAX_INFLIGHT));
    assign blk1    = (cnt1 == CNT_W'(MAX_INFLIGHT));
    assign d_fire  = out_d_valid & out_d_ready;
    assign d_beats = beats_of(out_d_opcode == 3'd1, out_d_size);
    // D messages never interleave, so one remaining-beat counter serves both.
    // A value of zero means the next D beat starts a new message.
    assign d_last  = (d_cnt == '0) ? (d_beats == BEAT_W'(1)) : (d_cnt == BEAT_W'(1));
    assign inc0    = fire & (state == IDLE) & ~grant;
    assign inc1    = fire & (state == IDLE) &  grant;
    assign dec0    = d_fire & d_last & ~sel & (cnt0 != '0);
    assign dec1    = d_fire & d_last &  sel & (cnt1 != '0);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt0  <= '0;
            cnt1  <= '0;
            d_cnt <= '0;
        end else begin
            if (d_fire) d_cnt <= (d_cnt == '0) ? d_beats - 1'b1 : d_cnt - 1'b1;
            if (inc0 && !dec0)      cnt0 <= cnt0 + 1'b1;
            else if (dec0 && !inc0) cnt0 <= cnt0 - 1'b1;
            if (inc1 && !dec1)      cnt1 <= cnt1 + 1'b1;
            else if (dec1 && !inc1) cnt1 <= cnt1 - 1'b1;
        end
    end
`else
    assign blk0 = 1'b0;
    assign blk1 = 1'b0;
`endif

endmodule

// File: tb/tb_tl_ul_a_arbiter.sv
module tb_tl_ul_a_arbiter;
  localparam int SRC_W        = 3;
  localparam int MAX_SIZE     = 6;
  localparam int MAX_INFLIGHT = 4;
  localparam logic [2:0] PUT_FULL = 3'd0;
  localparam logic [2:0] PUT_PART = 3'd1;
  localparam logic [2:0] GET      = 3'd4;

  logic clock, reset_n;
  logic a0_valid, a0_ready, a1_valid, a1_ready;
  logic [2:0] a0_opcode, a0_param, a1_opcode, a1_param;
  logic [3:0] a0_size, a1_size, a0_mask, a1_mask;
  logic [SRC_W-1:0] a0_source, a1_source;
  logic [31:0] a0_address, a1_address, a0_data, a1_data;
  logic out_a_valid, out_a_ready;
  logic [2:0] out_a_opcode, out_a_param;
  logic [3:0] out_a_size, out_a_mask;
  logic [SRC_W:0] out_a_source;
  logic [31:0] out_a_address, out_a_data;
  logic out_d_valid, out_d_ready;
  logic [2:0] out_d_opcode;
  logic [1:0] out_d_param;
  logic [3:0] out_d_size;
  logic [SRC_W:0] out_d_source;
  logic out_d_denied, out_d_corrupt;
  logic [31:0] out_d_data;
  logic d0_valid, d0_ready, d0_denied, d0_corrupt;
  logic d1_valid, d1_ready, d1_denied, d1_corrupt;
  logic [2:0] d0_opcode, d1_opcode;
  logic [1:0] d0_param, d1_param;
  logic [3:0] d0_size, d1_size;
  logic [SRC_W-1:0] d0_source, d1_source;
  logic [31:0] d0_data, d1_data;
  logic err_size, dbg_state;

  tl_ul_a_arbiter #(.SRC_W(SRC_W), .MAX_SIZE(MAX_SIZE), .MAX_INFLIGHT(MAX_INFLIGHT)) dut (
    .clock(clock), .reset_n(reset_n),
    .a0_valid(a0_valid), .a0_ready(a0_ready), .a0_opcode(a0_opcode), .a0_param(a0_param),
    .a0_size(a0_size), .a0_source(a0_source), .a0_address(a0_address), .a0_mask(a0_mask), .a0_data(a0_data),
    .a1_valid(a1_valid), .a1_ready(a1_ready), .a1_opcode(a1_opcode), .a1_param(a1_param),
    .a1_size(a1_size), .a1_source(a1_source), .a1_address(a1_address), .a1_mask(a1_mask), .a1_data(a1_data),
    .out_a_valid(out_a_valid), .out_a_ready(out_a_ready), .out_a_opcode(out_a_opcode), .out_a_param(out_a_param),
    .out_a_size(out_a_size), .out_a_source(out_a_source), .out_a_address(out_a_address),
    .out_a_mask(out_a_mask), .out_a_data(out_a_data),
    .out_d_valid(out_d_valid), .out_d_ready(out_d_ready), .out_d_opcode(out_d_opcode), .out_d_param(out_d_param),
    .out_d_size(out_d_size), .out_d_source(out_d_source), .out_d_denied(out_d_denied),
    .out_d_data(out_d_data), .out_d_corrupt(out_d_corrupt),
    .d0_valid(d0_valid), .d0_ready(d0_ready), .d0_opcode(d0_opcode), .d0_param(d0_param), .d0_size(d0_size),
    .d0_source(d0_source), .d0_denied(d0_denied), .d0_data(d0_data), .d0_corrupt(d0_corrupt),
    .d1_valid(d1_valid), .d1_ready(d1_ready), .d1_opcode(d1_opcode), .d1_param(d1_param), .d1_size(d1_size),
    .d1_source(d1_source), .d1_denied(d1_denied), .d1_data(d1_data), .d1_corrupt(d1_corrupt),
    .err_size(err_size), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_a(input int who, input logic v, input logic [2:0] op, input logic [3:0] sz,
                         input logic [2:0] src, input logic [31:0] addr, input logic [3:0] mask,
                         input logic [31:0] data);
    if (who == 0) begin
      a0_valid = v; a0_opcode = op; a0_param = 3'd0; a0_size = sz; a0_source = src;
      a0_address = addr; a0_mask = mask; a0_data = data;
    end else begin
      a1_valid = v; a1_opcode = op; a1_param = 3'd0; a1_size = sz; a1_source = src;
      a1_address = addr; a1_mask = mask; a1_data = data;
    end
  endtask

  task automatic drive_d(input logic v, input logic [3:0] src, input logic [2:0] op, input logic [3:0] sz,
                         input logic [31:0] data, input logic r0, input logic r1);
    out_d_valid = v; out_d_source = src; out_d_opcode = op; out_d_size = sz; out_d_data = data;
    out_d_param = 2'd0; out_d_denied = 1'b0; out_d_corrupt = 1'b0;
    d0_ready = r0; d1_ready = r1;
  endtask

  task automatic idle_inputs();
    drive_a(0, 1'b0, GET, 4'd2, 3'd0, 32'h0, 4'hf, 32'h0);
    drive_a(1, 1'b0, GET, 4'd2, 3'd0, 32'h0, 4'hf, 32'h0);
    drive_d(1'b0, 4'h0, 3'd0, 4'd2, 32'h0, 1'b0, 1'b0);
    out_a_ready = 1'b0;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    tick();
  endtask

  // ---------------- vector tables ----------------
  typedef struct {
    logic a0v, a1v, rdy;
    logic [2:0] s0, s1;
    logic exp_v, exp_r0, exp_r1;
    logic [3:0] exp_src;
  } a_vec_t;

  typedef struct {
    logic dv;
    logic [3:0] src;
    logic r0, r1;
    logic exp_d0v, exp_d1v, exp_rdy;
  } d_vec_t;

  a_vec_t a_tab[4];
  d_vec_t d_tab[6];

  // ---------------- random-phase model data ----------------
  typedef struct packed {
    logic [2:0] op;
    logic [3:0] size;
    logic [2:0] src;
    logic [31:0] addr;
    logic [3:0] mask;
    logic [31:0] data;
  } beat_t;
  localparam int W = 1 + $bits(beat_t);

  beat_t b0[$], b1[$];
  int nb0[$], nb1[$];
  logic [W-1:0] exp_q[$];

  // ---------------- scoreboard / stimulus ----------------
  initial begin
    int nmsg, cyc, p0, p1, i0, i1, o0, o1, turn, pick;
    logic [W-1:0] act;
    logic [3:0] rs;
    logic rdv, rr0, rr1;
    logic [31:0] rdata;

    // Reset state: outputs are held quiet even with requests pending.
    reset_n = 1'b0;
    idle_inputs();
    a0_valid = 1'b1; a1_valid = 1'b1; out_a_ready = 1'b1;
    out_d_valid = 1'b1; d0_ready = 1'b1;
    #12;
    check("reset_quiet", 128'({out_a_valid, a0_ready, a1_ready, d0_valid, d1_valid}), 128'(5'b0));
    check("reset_regs", 128'({err_size, dbg_state}), 128'(2'b0));
    @(negedge clock);
    idle_inputs();
    reset_n = 1'b1;
    tick();

    // Combinational grant table, prio=0; valids are dropped before each edge.
    a_tab[0] = '{1, 0, 1, 3'd5, 3'd2, 1, 1, 0, 4'h5};
    a_tab[1] = '{0, 1, 1, 3'd5, 3'd2, 1, 0, 1, 4'hA};
    a_tab[2] = '{1, 1, 1, 3'd5, 3'd2, 1, 1, 0, 4'h5};
    a_tab[3] = '{1, 1, 0, 3'd5, 3'd2, 1, 0, 0, 4'h5};
    for (int i = 0; i < 4; i++) begin
      drive_a(0, a_tab[i].a0v, GET, 4'd2, a_tab[i].s0, 32'h1000, 4'hf, 32'h0);
      drive_a(1, a_tab[i].a1v, GET, 4'd2, a_tab[i].s1, 32'h2000, 4'hf, 32'h0);
      out_a_ready = a_tab[i].rdy;
      @(negedge clock);
      check($sformatf("a_tab[%0d]", i), 128'({out_a_valid, a0_ready, a1_ready, out_a_source}),
            128'({a_tab[i].exp_v, a_tab[i].exp_r0, a_tab[i].exp_r1, a_tab[i].exp_src}));
      idle_inputs();
      tick();
    end

    // D routing table.
    d_tab[0] = '{1, 4'h5, 1, 0, 1, 0, 1};
    d_tab[1] = '{1, 4'h5, 0, 1, 1, 0, 0};
    d_tab[2] = '{1, 4'hD, 0, 1, 0, 1, 1};
    d_tab[3] = '{1, 4'h8, 1, 0, 0, 1, 0};
    d_tab[4] = '{0, 4'h5, 1, 1, 0, 0, 1};
    d_tab[5] = '{0, 4'hC, 0, 0, 0, 0, 0};
    for (int i = 0; i < 6; i++) begin
      drive_d(d_tab[i].dv, d_tab[i].src, 3'd1, 4'd2, 32'hCAFE0000 + 32'(i), d_tab[i].r0, d_tab[i].r1);
      @(negedge clock);
      check($sformatf("d_tab[%0d]", i), 128'({d0_valid, d1_valid, out_d_ready, d0_source, d1_source}),
            128'({d_tab[i].exp_d0v, d_tab[i].exp_d1v, d_tab[i].exp_rdy, d_tab[i].src[2:0], d_tab[i].src[2:0]}));
      idle_inputs();
      tick();
    end

    // Single requester Get.
    do_reset();
    drive_a(0, 1'b1, GET, 4'd2, 3'd5, 32'h1000, 4'hf, 32'h0);
    out_a_ready = 1'b1;
    @(negedge clock);
    check("single_src", 128'({out_a_valid, out_a_source, a1_ready, out_a_address}), 128'({1'b1, 4'h5, 1'b0, 32'h1000}));
    tick();
    a0_valid = 1'b0;
    @(negedge clock);
    check("single_done", 128'(out_a_valid), 128'(1'b0));
    tick();

    // Contention: grants alternate 0,1,0,1.
    do_reset();
    drive_a(0, 1'b1, GET, 4'd2, 3'd1, 32'h100, 4'hf, 32'h0);
    drive_a(1, 1'b1, GET, 4'd2, 3'd2, 32'h200, 4'hf, 32'h0);
    out_a_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      check($sformatf("contend[%0d]", k), 128'(out_a_source), 128'((k % 2) ? 4'hA : 4'h1));
      tick();
    end
    idle_inputs();

    // Burst lock: a1 4-beat PutFull is not interrupted by a0.
    do_reset();
    drive_a(1, 1'b1, PUT_FULL, 4'd4, 3'd3, 32'h300, 4'hf, 32'h11);
    out_a_ready = 1'b1;
    @(negedge clock);
    check("burst_beat0", 128'(out_a_source), 128'(4'hB));
    tick();
    drive_a(0, 1'b1, GET, 4'd2, 3'd1, 32'h100, 4'hf, 32'h0);
    for (int k = 1; k < 4; k++) begin
      @(negedge clock);
      check($sformatf("burst_beat%0d", k), 128'({out_a_source, a0_ready}), 128'({4'hB, 1'b0}));
      tick();
    end
    @(negedge clock);
    check("burst_then_a0", 128'({out_a_source, dbg_state, err_size}), 128'({4'h1, 1'b0, 1'b0}));
    idle_inputs();
    tick();

    // Hold stability: prio=1, a0 stalled, a1 arrives later, grant stays 0.
    do_reset();
    drive_a(0, 1'b1, GET, 4'd2, 3'd1, 32'h100, 4'hf, 32'h0);
    out_a_ready = 1'b1;
    tick();
    drive_a(0, 1'b1, GET, 4'd2, 3'd6, 32'h600, 4'hf, 32'h0);
    out_a_ready = 1'b0;
    @(negedge clock);
    check("hold_start", 128'(out_a_source), 128'(4'h6));
    tick();
    drive_a(1, 1'b1, GET, 4'd2, 3'd2, 32'h200, 4'hf, 32'h0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      check($sformatf("hold[%0d]", k), 128'({out_a_source, a1_ready, out_a_address}), 128'({4'h6, 1'b0, 32'h600}));
      tick();
    end
    out_a_ready = 1'b1;
    @(negedge clock);
    check("hold_fire", 128'({out_a_source, a0_ready}), 128'({4'h6, 1'b1}));
    tick();
    a0_valid = 1'b0;
    @(negedge clock);
    check("hold_release", 128'(out_a_source), 128'(4'hA));
    idle_inputs();
    tick();

    // Oversized PutFull: 16 beats, sticky err_size.
    do_reset();
    drive_a(0, 1'b1, PUT_FULL, 4'd7, 3'd4, 32'h400, 4'hf, 32'h77);
    out_a_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      @(negedge clock);
      check($sformatf("big_beat%0d", k), 128'({out_a_valid, out_a_source, dbg_state, err_size}),
            128'({1'b1, 4'h4, k != 0, k != 0}));
      tick();
    end
    drive_a(0, 1'b1, GET, 4'd2, 3'd4, 32'h400, 4'hf, 32'h0);
    @(negedge clock);
    check("big_done", 128'({dbg_state, err_size}), 128'(2'b01));
    tick();
    idle_inputs();
    @(negedge clock);
    check("err_sticky", 128'(err_size), 128'(1'b1));
    do_reset();
    check("err_cleared", 128'(err_size), 128'(1'b0));

`ifdef TL_ARB_INFLIGHT_LIMIT_EN
    // Inflight limit: four open Gets from a0 mask it until a D returns.
    do_reset();
    drive_a(0, 1'b1, GET, 4'd2, 3'd0, 32'h100, 4'hf, 32'h0);
    out_a_ready = 1'b1;
    repeat (MAX_INFLIGHT) begin
      @(negedge clock);
      tick();
    end
    drive_a(1, 1'b1, GET, 4'd2, 3'd1, 32'h200, 4'hf, 32'h0);
    for (int k = 0; k < 2; k++) begin
      @(negedge clock);
      check($sformatf("limit_a1[%0d]", k), 128'({out_a_valid, out_a_source[SRC_W], a0_ready}), 128'(3'b110));
      tick();
    end
    a1_valid = 1'b0;
    @(negedge clock);
    check("limit_a0_blocked", 128'({out_a_valid, a0_ready}), 128'(2'b00));
    tick();
    drive_d(1'b1, 4'h0, 3'd0, 4'd2, 32'h0, 1'b1, 1'b0);
    tick();
    drive_d(1'b0, 4'h0, 3'd0, 4'd2, 32'h0, 1'b0, 1'b0);
    @(negedge clock);
    check("limit_a0_reenabled", 128'({out_a_valid, out_a_source[SRC_W], a0_ready}), 128'(3'b101));
    idle_inputs();
    tick();
    nmsg = MAX_INFLIGHT;
`else
    nmsg = 10;
`endif

    // Randomized phase: both requesters start with a full message list.
    do_reset();
    for (int r = 0; r < 2; r++) begin
      for (int m = 0; m < nmsg; m++) begin
        beat_t bt;
        int nb;
        case ($urandom_range(0, 2))
          0:       bt.op = PUT_FULL;
          1:       bt.op = PUT_PART;
          default: bt.op = GET;
        endcase
        bt.size = 4'($urandom_range(0, MAX_SIZE));
        bt.src  = 3'($urandom_range(0, 7));
        bt.addr = $urandom;
        nb = (bt.op != GET && bt.size > 2) ? (1 << (bt.size - 2)) : 1;
        for (int j = 0; j < nb; j++) begin
          bt.mask = 4'($urandom_range(0, 15));
          bt.data = $urandom;
          if (r == 0) b0.push_back(bt); else b1.push_back(bt);
        end
        if (r == 0) nb0.push_back(nb); else nb1.push_back(nb);
      end
    end
    // Reference order: whole messages alternate between requesters, starting at 0,
    // and the other side takes every turn once one list is exhausted.
    i0 = 0; i1 = 0; o0 = 0; o1 = 0; turn = 0;
    while (i0 < nb0.size() || i1 < nb1.size()) begin
      if (turn == 0) pick = (i0 < nb0.size()) ? 0 : 1;
      else           pick = (i1 < nb1.size()) ? 1 : 0;
      if (pick == 0) begin
        for (int j = 0; j < nb0[i0]; j++) exp_q.push_back({1'b0, b0[o0 + j]});
        o0 += nb0[i0]; i0++;
      end else begin
        for (int j = 0; j < nb1[i1]; j++) exp_q.push_back({1'b1, b1[o1 + j]});
        o1 += nb1[i1]; i1++;
      end
      turn = 1 - pick;
    end

    p0 = 0; p1 = 0; cyc = 0;
    while (exp_q.size() > 0 && cyc < 5000) begin
      if (p0 < b0.size()) drive_a(0, 1'b1, b0[p0].op, b0[p0].size, b0[p0].src, b0[p0].addr, b0[p0].mask, b0[p0].data);
      else                a0_valid = 1'b0;
      if (p1 < b1.size()) drive_a(1, 1'b1, b1[p1].op, b1[p1].size, b1[p1].src, b1[p1].addr, b1[p1].mask, b1[p1].data);
      else                a1_valid = 1'b0;
      out_a_ready = ($urandom_range(0, 3) != 0);
      rdv = 1'($urandom_range(0, 1)); rs = 4'($urandom_range(0, 15));
      rr0 = 1'($urandom_range(0, 1)); rr1 = 1'($urandom_range(0, 1)); rdata = $urandom;
      drive_d(rdv, rs, 3'($urandom_range(0, 1)), 4'($urandom_range(0, 6)), rdata, rr0, rr1);
      @(negedge clock);
      check("rand_d", 128'({d0_valid, d1_valid, out_d_ready, d0_source, d1_data}),
            128'({rdv & ~rs[3], rdv & rs[3], rs[3] ? rr1 : rr0, rs[2:0], rdata}));
      if (out_a_valid && out_a_ready) begin
        act = {out_a_source[SRC_W], out_a_opcode, out_a_size, out_a_source[SRC_W-1:0],
               out_a_address, out_a_mask, out_a_data};
        check("rand_a_beat", 128'(act), 128'(exp_q.pop_front()));
        if (a0_ready)      p0++;
        else if (a1_ready) p1++;
      end
      tick();
      cyc++;
    end
    check("rand_a_drained", 128'(exp_q.size()), 128'(0));
    idle_inputs();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
